// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared types and constants for the forwarding/hazard slice
package cpu_types_pkg;

  localparam int DEF_REGW = 5;
  localparam int DEF_NFWD = 2;
  localparam int DEF_SELW = $clog2(DEF_NFWD + 1);

  typedef logic [DEF_REGW-1:0] regbits_t;
  typedef logic [DEF_SELW-1:0] fwd_sel_t;

  // Select 0 reads the register file; stage k is encoded as FWD_STG0 + k.
  localparam fwd_sel_t FWD_REGFILE = fwd_sel_t'(0);
  localparam fwd_sel_t FWD_STG0    = fwd_sel_t'(1);

  function automatic int stage_code(input int k);
    return k + int'(FWD_STG0);
  endfunction

endpackage

// File: rtl/fwd_prio_sel.sv
// rtl/fwd_prio_sel.sv - priority bypass select for one EX operand
module fwd_prio_sel
  import cpu_types_pkg::*;
#(
  parameter int NFWD = DEF_NFWD,
  parameter int REGW = DEF_REGW,
  parameter int SELW = $clog2(NFWD + 1)
) (
  input  logic [REGW-1:0]      src,
  input  logic [NFWD-1:0]      stg_wen,
  input  logic [NFWD*REGW-1:0] stg_rd,
  output logic [SELW-1:0]      sel
);

  // Walk oldest to youngest so the youngest matching producer is the last writer.
  always_comb begin
    sel = SELW'(FWD_REGFILE);
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (stg_wen[k] && (stg_rd[k*REGW +: REGW] == src) && (src != '0)) begin
        sel = SELW'(stage_code(k));
      end
    end
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// rtl/forward_hazard_unit.sv - EX bypass selects plus long-latency scoreboard and ID stall
module forward_hazard_unit
  import cpu_types_pkg::*;
#(
  parameter  int NREAD    = 2,
  parameter  int NFWD     = DEF_NFWD,
  parameter  int REGW     = DEF_REGW,
  parameter  int MAX_PEND = 4,
  parameter  int CNTW     = 32,
  localparam int SELW     = $clog2(NFWD + 1),
  localparam int PCW      = $clog2(MAX_PEND + 1),
  localparam int NREGS    = 2 ** REGW
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [NREAD*REGW-1:0]  ex_src,
  input  logic [NFWD-1:0]        stg_wen,
  input  logic [NFWD*REGW-1:0]   stg_rd,
  output logic [NREAD*SELW-1:0]  fwd_sel,
  input  logic [NREAD*REGW-1:0]  id_src,
  input  logic [NREAD-1:0]       id_src_vld,
  input  logic                   id_longlat,
  input  logic                   ex_memread,
  input  logic [REGW-1:0]        ex_rd,
  input  logic                   lat_issue,
  input  logic                   done_vld,
  input  logic [REGW-1:0]        done_rd,
  output logic                   stall,
  output logic [PCW-1:0]         pend_cnt,
  output logic [CNTW-1:0]        stall_cycles,
  output logic                   sb_err
);

  logic [NREGS-1:0] sb;
  logic             set_en;
  logic             clr_en;
  logic             cnt_inc;
  logic             cnt_dec;

  for (genvar i = 0; i < NREAD; i++) begin : g_fwd
    fwd_prio_sel #(
      .NFWD (NFWD),
      .REGW (REGW),
      .SELW (SELW)
    ) u_sel (
      .src     (ex_src[i*REGW +: REGW]),
      .stg_wen (stg_wen),
      .stg_rd  (stg_rd),
      .sel     (fwd_sel[i*SELW +: SELW])
    );
  end

  // Stall on a pending long-latency source, on load-use, or when the scoreboard is full.
  always_comb begin
    stall = 1'b0;
    for (int i = 0; i < NREAD; i++) begin
      if (id_src_vld[i] && (id_src[i*REGW +: REGW] != '0) && sb[id_src[i*REGW +: REGW]]
          && !(done_vld && (done_rd == id_src[i*REGW +: REGW]))) begin
        stall = 1'b1;
      end
      if (id_src_vld[i] && ex_memread && (ex_rd != '0)
          && (ex_rd == id_src[i*REGW +: REGW])) begin
        stall = 1'b1;
      end
    end
    if (id_longlat && (pend_cnt == PCW'(MAX_PEND)) && !(done_vld && sb[done_rd])) begin
      stall = 1'b1;
    end
  end

  // A same-register set and completion resolves in favour of the set.
  always_comb begin
    set_en  = lat_issue && (ex_rd != '0) && !stall;
    clr_en  = done_vld && !(set_en && (done_rd == ex_rd));
    cnt_inc = set_en && !sb[ex_rd];
    cnt_dec = clr_en && sb[done_rd];
  end

  // Scoreboard bits, outstanding count and sticky completion-on-clear error.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sb       <= '0;
      pend_cnt <= '0;
      sb_err   <= 1'b0;
    end else begin
      if (clr_en) begin
        sb[done_rd] <= 1'b0;
      end
      if (set_en) begin
        sb[ex_rd] <= 1'b1;
      end
      if (clr_en && !sb[done_rd]) begin
        sb_err <= 1'b1;
      end
      if (cnt_inc && !cnt_dec && (pend_cnt != PCW'(MAX_PEND))) begin
        pend_cnt <= pend_cnt + PCW'(1);
      end else if (cnt_dec && !cnt_inc) begin
        pend_cnt <= pend_cnt - PCW'(1);
      end
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// tb/tb_forward_hazard_unit.sv - randomized scoreboard bench for forward_hazard_unit
module tb_forward_hazard_unit;

  localparam int NREAD    = 2;
  localparam int NFWD     = 2;
  localparam int REGW     = 5;
  localparam int MAX_PEND = 4;
  localparam int CNTW     = 32;
  localparam int SELW     = $clog2(NFWD + 1);
  localparam int PCW      = $clog2(MAX_PEND + 1);
  localparam int NREGS    = 2 ** REGW;

  logic                  CLK = 1'b0;
  logic                  nRST;
  logic [NREAD*REGW-1:0] ex_src;
  logic [NFWD-1:0]       stg_wen;
  logic [NFWD*REGW-1:0]  stg_rd;
  logic [NREAD*SELW-1:0] fwd_sel;
  logic [NREAD*REGW-1:0] id_src;
  logic [NREAD-1:0]      id_src_vld;
  logic                  id_longlat;
  logic                  ex_memread;
  logic [REGW-1:0]       ex_rd;
  logic                  lat_issue;
  logic                  done_vld;
  logic [REGW-1:0]       done_rd;
  logic                  stall;
  logic [PCW-1:0]        pend_cnt;
  logic [CNTW-1:0]       stall_cycles;
  logic                  sb_err;

  forward_hazard_unit #(
    .NREAD(NREAD), .NFWD(NFWD), .REGW(REGW), .MAX_PEND(MAX_PEND), .CNTW(CNTW)
  ) dut (
    .CLK(CLK), .nRST(nRST), .ex_src(ex_src), .stg_wen(stg_wen), .stg_rd(stg_rd),
    .fwd_sel(fwd_sel), .id_src(id_src), .id_src_vld(id_src_vld), .id_longlat(id_longlat),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .lat_issue(lat_issue), .done_vld(done_vld),
    .done_rd(done_rd), .stall(stall), .pend_cnt(pend_cnt), .stall_cycles(stall_cycles),
    .sb_err(sb_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [NREAD*SELW-1:0] fwd_sel;
    logic                  stall;
    logic [PCW-1:0]        pend;
    logic [CNTW-1:0]       scyc;
    logic                  err;
  } exp_t;

  exp_t expq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: set of pending registers, sticky error, stall count.
  bit     pend_set[NREGS];
  bit     m_err;
  longint m_scnt;

  function automatic int pend_count();
    int c = 0;
    for (int r = 0; r < NREGS; r++) c += int'(pend_set[r]);
    return c;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) pend_set[r] = 1'b0;
    m_err  = 1'b0;
    m_scnt = 0;
  endtask

  task automatic idle();
    ex_src = '0; stg_wen = '0; stg_rd = '0; id_src = '0; id_src_vld = '0;
    id_longlat = 1'b0; ex_memread = 1'b0; ex_rd = '0; lat_issue = 1'b0;
    done_vld = 1'b0; done_rd = '0;
  endtask

  // Push the expected response for the inputs now applied, then advance the model.
  task automatic cycle(input bit in_reset);
    exp_t e;
    bit   st;
    bit   set;
    int   s;
    int   sel;
    e.fwd_sel = '0;
    for (int i = 0; i < NREAD; i++) begin
      s   = int'(ex_src[i*REGW +: REGW]);
      sel = 0;
      for (int k = 0; k < NFWD; k++) begin
        if (sel == 0 && stg_wen[k] && int'(stg_rd[k*REGW +: REGW]) == s && s != 0) sel = k + 1;
      end
      e.fwd_sel[i*SELW +: SELW] = SELW'(sel);
    end
    st = 1'b0;
    for (int i = 0; i < NREAD; i++) begin
      s = int'(id_src[i*REGW +: REGW]);
      if (id_src_vld[i] && s != 0 && pend_set[s] && !(done_vld && int'(done_rd) == s)) st = 1'b1;
      if (id_src_vld[i] && ex_memread && ex_rd != 0 && int'(ex_rd) == s) st = 1'b1;
    end
    if (id_longlat && pend_count() == MAX_PEND && !(done_vld && pend_set[done_rd])) st = 1'b1;
    e.stall = st;
    e.pend  = PCW'(pend_count());
    e.scyc  = CNTW'(m_scnt);
    e.err   = m_err;
    expq.push_back(e);
    if (!in_reset) begin
      set = lat_issue && ex_rd != 0 && !st;
      if (done_vld && !(set && done_rd == ex_rd)) begin
        if (pend_set[done_rd]) pend_set[done_rd] = 1'b0;
        else m_err = 1'b1;
      end
      if (set) pend_set[ex_rd] = 1'b1;
      if (st && m_scnt < (64'd1 << CNTW) - 1) m_scnt++;
    end
    @(posedge CLK);
    #1;
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest queued expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      n_cmp++;
      if (fwd_sel !== e.fwd_sel) begin
        n_bad++; $display("FAIL fwd_sel: got %0h expected %0h at %0t", fwd_sel, e.fwd_sel, $time);
      end
      n_cmp++;
      if (stall !== e.stall) begin
        n_bad++; $display("FAIL stall: got %0b expected %0b at %0t", stall, e.stall, $time);
      end
      n_cmp++;
      if (pend_cnt !== e.pend) begin
        n_bad++; $display("FAIL pend_cnt: got %0d expected %0d at %0t", pend_cnt, e.pend, $time);
      end
      n_cmp++;
      if (stall_cycles !== e.scyc) begin
        n_bad++; $display("FAIL stall_cycles: got %0d expected %0d at %0t", stall_cycles, e.scyc, $time);
      end
      n_cmp++;
      if (sb_err !== e.err) begin
        n_bad++; $display("FAIL sb_err: got %0b expected %0b at %0t", sb_err, e.err, $time);
      end
    end
  end

  task automatic do_reset();
    nRST = 1'b0;
    model_reset();
    cycle(1'b1);
    nRST = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int plist[$];
    nRST = 1'b0;
    idle();
    model_reset();
    @(posedge CLK);
    #1;
    cycle(1'b1);
    nRST = 1'b1;

    // Youngest producer wins, then older stage when the younger drops write enable.
    idle(); ex_src[4:0] = 5'd3; stg_wen = 2'b11; stg_rd = {5'd3, 5'd3}; cycle(1'b0);
    stg_wen = 2'b10; cycle(1'b0);
    // $0 never forwards; no write enable never forwards.
    idle(); stg_wen = 2'b11; cycle(1'b0);
    stg_wen = 2'b00; ex_src = {5'd7, 5'd7}; stg_rd = {5'd7, 5'd7}; cycle(1'b0);
    // Load-use bubble.
    idle(); ex_memread = 1'b1; ex_rd = 5'd8; id_src[4:0] = 5'd8; id_src_vld = 2'b01; cycle(1'b0);
    idle(); cycle(1'b0);
    // Long-latency dependency with same-cycle completion bypass.
    lat_issue = 1'b1; ex_rd = 5'd9; cycle(1'b0);
    idle(); id_src[9:5] = 5'd9; id_src_vld = 2'b10; cycle(1'b0);
    done_vld = 1'b1; done_rd = 5'd9; cycle(1'b0);
    // Fill the scoreboard, full stall, relieved by a completion.
    for (int r = 1; r <= 4; r++) begin
      idle(); lat_issue = 1'b1; ex_rd = REGW'(r); cycle(1'b0);
    end
    idle(); id_longlat = 1'b1; cycle(1'b0);
    done_vld = 1'b1; done_rd = 5'd2; cycle(1'b0);
    // Same-register set and clear, then completion on a clear entry.
    idle(); lat_issue = 1'b1; ex_rd = 5'd5; done_vld = 1'b1; done_rd = 5'd5; cycle(1'b0);
    idle(); id_src[4:0] = 5'd5; id_src_vld = 2'b01; cycle(1'b0);
    idle(); done_vld = 1'b1; done_rd = 5'd6; cycle(1'b0);
    idle(); cycle(1'b0);
    do_reset();
    idle(); cycle(1'b0);

    // Randomized traffic over a small register window to force collisions.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        idle();
        ex_memread = 1'b1; ex_rd = REGW'($urandom_range(0, 7));
        id_src = {REGW'($urandom_range(0, 7)), REGW'($urandom_range(0, 7))};
        id_src_vld = 2'($urandom_range(0, 3));
        do_reset();
        continue;
      end
      for (int i = 0; i < NREAD; i++) begin
        ex_src[i*REGW +: REGW] = REGW'($urandom_range(0, 7));
        id_src[i*REGW +: REGW] = REGW'($urandom_range(0, 7));
      end
      for (int k = 0; k < NFWD; k++) stg_rd[k*REGW +: REGW] = REGW'($urandom_range(0, 7));
      stg_wen    = NFWD'($urandom_range(0, 2**NFWD - 1));
      id_src_vld = NREAD'($urandom_range(0, 2**NREAD - 1));
      id_longlat = ($urandom_range(0, 2) == 0);
      ex_memread = ($urandom_range(0, 3) == 0);
      ex_rd      = REGW'($urandom_range(0, 7));
      lat_issue  = ($urandom_range(0, 2) == 0) && (pend_count() < MAX_PEND);
      done_vld   = ($urandom_range(0, 2) == 0);
      plist.delete();
      for (int r = 0; r < NREGS; r++) if (pend_set[r]) plist.push_back(r);
      if (plist.size() > 0 && $urandom_range(0, 19) != 0)
        done_rd = REGW'(plist[$urandom_range(0, plist.size() - 1)]);
      else
        done_rd = REGW'($urandom_range(0, 7));
      cycle(1'b0);
    end

    idle();
    @(negedge CLK);
    #1;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
